hexd_ctrl: RTL

- Peripheral-side endpoint of the hex-display MMIO path. It accepts the 16-bit value and write strobe routed out of the MMIO crossbar and holds it as the CPU-visible register.
- It drives a time-multiplexed 4-digit common-anode 7-segment display and returns the register contents to the crossbar for MMIO readback.
- New values are committed to the display only at a scan-frame boundary, so a frame never shows a mix of old and new digits.

---
 rtl/hexd_ctrl.sv | 109 ++++++++++
 1 files changed

// File: rtl/hexd_ctrl.sv
// Hex-display MMIO endpoint: holds the CPU-visible 16-bit register and scans it
// onto a 4-digit common-anode 7-segment display, committing new values per frame.
module hexd_ctrl #(
    parameter int SCAN_DIV = 50000,
    parameter int DATA_W   = 16
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [DATA_W-1:0] i_hexd_data,
    input  logic              i_hexd_wren,
    output logic [DATA_W-1:0] o_hexd_rdata,
    output logic              o_hexd_pending,
    output logic [3:0]        o_anodes,
    output logic [6:0]        o_segs,
    output logic              o_dp
);

    localparam int DIGITS  = DATA_W / 4;
    localparam int IDX_W   = $clog2(DIGITS);
    localparam int PRESC_W = $clog2(SCAN_DIV);

    localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]   LAST_IDX  = IDX_W'(DIGITS - 1);

    logic [DATA_W-1:0]  data_reg;
    logic [DATA_W-1:0]  disp_reg;
    logic               pending;
    logic [PRESC_W-1:0] presc;
    logic [IDX_W-1:0]   idx;
    logic               tick;
    logic               frame_end;
    logic [3:0]         cur_nibble;

    // Active-low segment patterns, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] dec(input logic [3:0] nib);
        logic [6:0] seg;
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    assign tick       = (presc == PRESC_MAX);
    assign frame_end  = tick && (idx == LAST_IDX);
    assign cur_nibble = disp_reg[{idx, 2'b00} +: 4];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc <= '0;
            idx   <= '0;
        end else if (tick) begin
            presc <= '0;
            idx   <= idx + 1'b1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // A write landing on the frame boundary still wins: the old value commits
    // now and the new one stays pending for the next frame.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            data_reg <= '0;
            disp_reg <= '0;
            pending  <= 1'b0;
        end else begin
            if (frame_end && pending) begin
                disp_reg <= data_reg;
                pending  <= 1'b0;
            end
            if (i_hexd_wren) begin
                data_reg <= i_hexd_data;
                pending  <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_anodes <= 4'hF;
            o_segs   <= 7'h7F;
        end else begin
            o_anodes <= ~(4'b0001 << idx);
            o_segs   <= dec(cur_nibble);
        end
    end

    assign o_hexd_rdata   = data_reg;
    assign o_hexd_pending = pending;
    assign o_dp           = 1'b1;

endmodule
